// File: rtl/bure_pkg.sv
// Shared types and helpers for the bure fetch stage.
package bure_pkg;

    localparam int unsigned IFQ_ADDR_W  = 32;
    localparam int unsigned IFQ_INSTR_W = 32;
    localparam int unsigned INSTR_BYTES = IFQ_INSTR_W / 8;

    typedef struct packed {
        logic [IFQ_INSTR_W-1:0] instr;
        logic [IFQ_ADDR_W-1:0]  addr;
    } ifq_entry_t;

    // Width of a pointer/counter able to index `depth` positions; never below 1 bit.
    function automatic int unsigned ptr_width(input int unsigned depth);
        return (depth <= 1) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/cg_sync_fifo.sv
// Synchronous FIFO with flush; push while full is accepted when a pop happens in the same cycle.
module cg_sync_fifo
    import bure_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                              i_clk,
    input  logic                              i_rstn,
    input  logic                              i_flush,
    input  logic                              i_push,
    input  logic [WIDTH-1:0]                  i_data,
    input  logic                              i_pop,
    output logic [WIDTH-1:0]                  o_data,
    output logic [ptr_width(DEPTH + 1)-1:0]   o_count
);

    localparam int unsigned PtrW = ptr_width(DEPTH);
    localparam int unsigned CntW = ptr_width(DEPTH + 1);
    localparam logic [PtrW-1:0] LastIdx = PtrW'(DEPTH - 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q;
    logic [PtrW-1:0]  rd_ptr_q;
    logic [CntW-1:0]  count_q;
    logic             empty;
    logic             full;
    logic             do_push;
    logic             do_pop;

    always_comb begin
        empty   = (count_q == '0);
        full    = (count_q == CntW'(DEPTH));
        do_pop  = i_pop && !empty;
        do_push = i_push && (!full || do_pop);
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn || i_flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= (wr_ptr_q == LastIdx) ? '0 : wr_ptr_q + PtrW'(1);
            if (do_pop)  rd_ptr_q <= (rd_ptr_q == LastIdx) ? '0 : rd_ptr_q + PtrW'(1);
            count_q <= count_q + CntW'(do_push) - CntW'(do_pop);
        end
    end

    // Storage is not reset; validity lives entirely in count_q.
    always_ff @(posedge i_clk) begin
        if (do_push && !i_flush) mem_q[wr_ptr_q] <= i_data;
    end

    assign o_data  = mem_q[rd_ptr_q];
    assign o_count = count_q;

endmodule

// File: rtl/bure_stage_ifq.sv
// Instruction fetch queue: issues in-order memory reads under a credit limit and queues
// {instr, addr} pairs for decode; redirects flush the queue and discard stale responses.
module bure_stage_ifq
    import bure_pkg::*;
#(
    parameter int unsigned          ADDR_WIDTH      = IFQ_ADDR_W,
    parameter int unsigned          INSTR_WIDTH     = IFQ_INSTR_W,
    parameter int unsigned          FQ_DEPTH        = 4,
    parameter int unsigned          MAX_OUTSTANDING = 2,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC       = '0
) (
    input  logic                   i_clk,
    input  logic                   i_rstn,
    input  logic                   i_redirect,
    input  logic [ADDR_WIDTH-1:0]  i_redirect_pc,
    output logic                   o_imem_raddr_valid,
    input  logic                   i_imem_raddr_ready,
    output logic [ADDR_WIDTH-1:0]  o_imem_raddr,
    input  logic                   i_imem_rdata_valid,
    output logic                   o_imem_rdata_ready,
    input  logic [INSTR_WIDTH-1:0] i_imem_rdata,
    output logic                   o_instr_valid,
    input  logic                   i_instr_ready,
    output logic [INSTR_WIDTH-1:0] o_instr,
    output logic [ADDR_WIDTH-1:0]  o_instr_addr
);

    localparam int unsigned InstrBytes = INSTR_WIDTH / 8;
    localparam int unsigned OutW       = ptr_width(MAX_OUTSTANDING + 1);
    localparam int unsigned QcW        = ptr_width(FQ_DEPTH + 1);
    localparam int unsigned EntW       = INSTR_WIDTH + ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] AlignMask = ~ADDR_WIDTH'(InstrBytes - 1);
    localparam logic [ADDR_WIDTH-1:0] PcStep    = ADDR_WIDTH'(InstrBytes);

    logic [ADDR_WIDTH-1:0] pc_q;
    logic [OutW-1:0]       discard_q;
    logic [OutW-1:0]       af_count;
    logic [OutW-1:0]       outstanding;
    logic [QcW-1:0]        q_count;
    logic [ADDR_WIDTH-1:0] af_head;
    logic [EntW-1:0]       q_head;
    logic [31:0]           inflight;
    logic                  issue;
    logic                  rsp_keep;
    logic                  q_pop;

    // Discarded responses are tracked outside the address FIFO, which is flushed on redirect.
    always_comb begin
        outstanding        = af_count + discard_q;
        inflight           = 32'(outstanding) + 32'(q_count);
        o_imem_raddr_valid = i_rstn && !i_redirect && (32'(outstanding) < MAX_OUTSTANDING)
                             && (inflight < FQ_DEPTH);
        issue              = o_imem_raddr_valid && i_imem_raddr_ready;
        rsp_keep           = i_imem_rdata_valid && (discard_q == '0) && !i_redirect;
        o_instr_valid      = i_rstn && (q_count != '0);
        q_pop              = o_instr_valid && i_instr_ready && !i_redirect;
    end

    assign o_imem_raddr       = pc_q;
    assign o_imem_rdata_ready = 1'b1;
    assign o_instr            = q_head[EntW-1 -: INSTR_WIDTH];
    assign o_instr_addr       = q_head[ADDR_WIDTH-1:0];

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            pc_q      <= RESET_PC;
            discard_q <= '0;
        end else if (i_redirect) begin
            pc_q      <= i_redirect_pc & AlignMask;
            discard_q <= outstanding - OutW'(i_imem_rdata_valid);
        end else begin
            if (issue) pc_q <= pc_q + PcStep;
            if (i_imem_rdata_valid && (discard_q != '0)) discard_q <= discard_q - OutW'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rstn && i_imem_rdata_valid) begin
            assert (outstanding != '0)
            else $error("bure_stage_ifq: read response with no outstanding request");
        end
    end

    cg_sync_fifo #(
        .WIDTH (ADDR_WIDTH),
        .DEPTH (MAX_OUTSTANDING)
    ) u_addr_fifo (
        .i_clk   (i_clk),
        .i_rstn  (i_rstn),
        .i_flush (i_redirect),
        .i_push  (issue),
        .i_data  (pc_q),
        .i_pop   (rsp_keep),
        .o_data  (af_head),
        .o_count (af_count)
    );

    cg_sync_fifo #(
        .WIDTH (EntW),
        .DEPTH (FQ_DEPTH)
    ) u_instr_fifo (
        .i_clk   (i_clk),
        .i_rstn  (i_rstn),
        .i_flush (i_redirect),
        .i_push  (rsp_keep),
        .i_data  ({i_imem_rdata, af_head}),
        .i_pop   (q_pop),
        .o_data  (q_head),
        .o_count (q_count)
    );

endmodule

// File: tb/tb_bure_stage_ifq.sv
// Self-checking bench for bure_stage_ifq: in-order memory model, scoreboard and redirect table.
module tb_bure_stage_ifq;
    import bure_pkg::*;

    localparam logic [31:0] RST_PC = 32'h100;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        raddr_valid;
    logic        raddr_ready = 1'b0;
    logic [31:0] raddr;
    logic        rdata_valid = 1'b0;
    logic        rdata_ready;
    logic [31:0] rdata = '0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr;
    logic [31:0] instr_addr;

    always #5 clk = ~clk;

    bure_stage_ifq #(
        .ADDR_WIDTH      (32),
        .INSTR_WIDTH     (32),
        .FQ_DEPTH        (4),
        .MAX_OUTSTANDING (2),
        .RESET_PC        (RST_PC)
    ) dut (
        .i_clk              (clk),
        .i_rstn             (rstn),
        .i_redirect         (redirect),
        .i_redirect_pc      (redirect_pc),
        .o_imem_raddr_valid (raddr_valid),
        .i_imem_raddr_ready (raddr_ready),
        .o_imem_raddr       (raddr),
        .i_imem_rdata_valid (rdata_valid),
        .o_imem_rdata_ready (rdata_ready),
        .i_imem_rdata       (rdata),
        .o_instr_valid      (instr_valid),
        .i_instr_ready      (instr_ready),
        .o_instr            (instr),
        .o_instr_addr       (instr_addr)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    typedef struct {
        logic [31:0] rpc;
        logic [31:0] exp_addr;
        int          delay;
    } redir_vec_t;

    pend_t       pending[$];
    ifq_entry_t  sb[$];
    redir_vec_t  vecs[4];
    logic [31:0] exp_pc = RST_PC;
    logic [31:0] last_pop_addr;
    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    int          mem_delay = 1;
    bit          hs_now;
    bit          pop_now;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return {a[15:0] ^ 16'h5a5a, ~a[15:0]};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock cycle: drive controls and memory response after the edge, check at negedge.
    task automatic cycle(input logic rst_n, input logic red, input logic [31:0] rpc,
                         input logic mrdy, input logic drdy);
        ifq_entry_t e;
        @(posedge clk);
        #1;
        rstn        = rst_n;
        redirect    = red;
        redirect_pc = rpc;
        raddr_ready = mrdy;
        instr_ready = drdy;
        cyc++;
        if (pending.size() > 0 && pending[0].due <= cyc) begin
            rdata_valid = 1'b1;
            rdata       = mem_data(pending[0].addr);
            void'(pending.pop_front());
        end else begin
            rdata_valid = 1'b0;
            rdata       = '0;
        end
        @(negedge clk);
        hs_now  = rstn && raddr_valid && raddr_ready;
        pop_now = rstn && instr_valid && instr_ready && !redirect;
        if (!rstn) begin
            check("rst_raddr_valid", 64'(raddr_valid), 64'd0);
            check("rst_instr_valid", 64'(instr_valid), 64'd0);
            check("rst_rdata_ready", 64'(rdata_ready), 64'd1);
            pending.delete();
            sb.delete();
            exp_pc = RST_PC;
        end else begin
            if (hs_now) begin
                check("issue_addr", 64'(raddr), 64'(exp_pc));
                pending.push_back('{addr: raddr, due: cyc + mem_delay});
                sb.push_back('{instr: mem_data(exp_pc), addr: exp_pc});
                exp_pc = exp_pc + 32'd4;
            end
            if (pop_now) begin
                last_pop_addr = instr_addr;
                if (sb.size() == 0) begin
                    check("pop_unexpected", 64'(instr_addr), 64'hdead_beef);
                end else begin
                    e = sb.pop_front();
                    check("pop_addr", 64'(instr_addr), 64'(e.addr));
                    check("pop_instr", 64'(instr), 64'(e.instr));
                end
            end
            if (redirect) begin
                check("redirect_no_issue", 64'(raddr_valid), 64'd0);
                sb.delete();
                exp_pc = rpc & ~32'h3;
            end
        end
    endtask

    // Stop issuing, let decode drain everything in flight, return the number of pops.
    task automatic drain(output int pops);
        pops = 0;
        for (int i = 0; i < 40; i++) begin
            cycle(1'b1, 1'b0, '0, 1'b0, 1'b1);
            pops += int'(pop_now);
            if (pending.size() == 0 && !rdata_valid && !instr_valid) break;
        end
        check("drain_sb_empty", 64'(sb.size()), 64'd0);
        check("drain_valid_low", 64'(instr_valid), 64'd0);
    endtask

    initial begin
        int n;
        bit found;

        vecs[0] = '{rpc: 32'h0000_2002, exp_addr: 32'h0000_2000, delay: 3};
        vecs[1] = '{rpc: 32'h0000_3003, exp_addr: 32'h0000_3000, delay: 2};
        vecs[2] = '{rpc: 32'hffff_fffe, exp_addr: 32'hffff_fffc, delay: 1};
        vecs[3] = '{rpc: 32'h0000_0044, exp_addr: 32'h0000_0044, delay: 3};

        cycle(1'b0, 1'b0, '0, 1'b1, 1'b1);
        cycle(1'b0, 1'b0, '0, 1'b1, 1'b1);

        // Streaming from reset: back-to-back requests at RESET_PC, +4, +8.
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b0, '0, 1'b1, 1'b1);
            check("stream_valid", 64'(raddr_valid), 64'd1);
            check("stream_addr", 64'(raddr), 64'(RST_PC + 32'(4 * i)));
        end
        for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, '0, 1'b1, 1'b1);
        drain(n);

        // Decode stalled: exactly FQ_DEPTH requests, then one pop per cycle.
        n = 0;
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, 1'b0, '0, 1'b1, 1'b0);
            n += int'(hs_now);
        end
        check("stall_issue_count", 64'(n), 64'd4);
        check("stall_valid_low", 64'(raddr_valid), 64'd0);
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 1'b0, '0, 1'b0, 1'b1);
            check("stall_pop_each_cycle", 64'(pop_now), 64'd1);
        end
        drain(n);
        check("stall_drain_extra", 64'(n), 64'd0);

        // Push and pop together at the credit limit.
        for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, '0, 1'b1, 1'b0);
        cycle(1'b1, 1'b0, '0, 1'b0, 1'b1);
        check("limit_pop", 64'(pop_now), 64'd1);
        cycle(1'b1, 1'b0, '0, 1'b1, 1'b0);
        check("limit_refill_issue", 64'(hs_now), 64'd1);
        cycle(1'b1, 1'b0, '0, 1'b0, 1'b1);
        check("limit_push_pop", 64'({rdata_valid, pop_now}), 64'd3);
        drain(n);
        check("limit_remaining", 64'(n), 64'd3);

        // Memory back-pressure: request held, PC not advancing.
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 1'b0, '0, 1'b0, 1'b1);
            check("bp_valid_held", 64'(raddr_valid), 64'd1);
            check("bp_addr_stable", 64'(raddr), 64'(exp_pc));
        end
        cycle(1'b1, 1'b0, '0, 1'b1, 1'b1);
        check("bp_release_hs", 64'(hs_now), 64'd1);
        drain(n);

        // Redirect table: stale responses dropped, first entry at the aligned target.
        for (int v = 0; v < 4; v++) begin
            mem_delay = vecs[v].delay;
            cycle(1'b1, 1'b0, '0, 1'b1, 1'b1);
            cycle(1'b1, 1'b0, '0, 1'b1, 1'b1);
            cycle(1'b1, 1'b1, vecs[v].rpc, 1'b1, 1'b1);
            cycle(1'b1, 1'b0, '0, 1'b1, 1'b1);
            check("redir_flushed", 64'(instr_valid), 64'd0);
            found = 1'b0;
            for (int i = 0; i < 20 && !found; i++) begin
                cycle(1'b1, 1'b0, '0, 1'b1, 1'b1);
                if (pop_now) found = 1'b1;
            end
            check("redir_first_seen", 64'(found), 64'd1);
            if (found) check("redir_first_addr", 64'(last_pop_addr), 64'(vecs[v].exp_addr));
            drain(n);
            mem_delay = 1;
        end

        // Reset mid-stream with three queued entries.
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, '0, 1'b1, 1'b0);
        cycle(1'b1, 1'b0, '0, 1'b0, 1'b0);
        check("pre_reset_valid", 64'(instr_valid), 64'd1);
        cycle(1'b0, 1'b0, '0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, '0, 1'b1, 1'b1);
        check("post_reset_instr_valid", 64'(instr_valid), 64'd0);
        check("post_reset_issue", 64'(raddr_valid), 64'd1);
        check("post_reset_addr", 64'(raddr), 64'(RST_PC));
        cycle(1'b1, 1'b0, '0, 1'b1, 1'b1);
        check("post_reset_second_issue", 64'(hs_now), 64'd1);
        drain(n);
        check("post_reset_pops", 64'(n), 64'd2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
